muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle sequencer and HI/LO owner for the EX-stage multiply/divide path of the pipelined MIPS32 core. It accepts MULT, DIV, MTHI, MTLO, MFHI and MFLO from the EX stage and drives an internal `mul_div_unit`, which is combinational. Operands are held stable for a parameterised number of cycles, so the unit's long paths are multicycle paths, and the result is then captured into HI/LO. The block stalls the pipeline for any multiply/divide-class operation issued while a computation is in flight.

## Interface
Parameters:
- `MUL_CYCLES`, 2, cycles operands are held before a multiply result is captured; must be ≥1.
- `DIV_CYCLES`, 4, cycles operands are held before a divide result is captured; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  EX-stage operation present this cycle.
- `op_code`  in  3  operation, encoded per `muldiv_pkg`.
- `rs_val`  in  32  first operand: dividend or multiplicand, or the MTHI/MTLO source.
- `rt_val`  in  32  second operand: divisor or multiplier.
- `flush`  in  1  pipeline flush; aborts any in-flight computation and drops the current op.
- `stall`  out  1  combinational; holds the EX stage and everything upstream of it.
- `busy`  out  1  registered; high while a computation is in flight.
- `mf_data`  out  32  combinational; HI for MFHI, LO for MFLO, 0 for every other op.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- Reset values: state IDLE, counter 0, held operands 0, select 0, `busy` 0, `hi` 0, `lo` 0. The combinational outputs follow from these values.
- Acceptance: an op is accepted when `op_valid && !stall && !flush`.
- Stall rule: `stall = op_valid && busy && (op_code ∈ {MULT, DIV, MTHI, MTLO, MFHI, MFLO})`. NOP and non-multiply/divide traffic never stalls.
- States: IDLE and RUN.
- IDLE, MULT or DIV accepted:
  - Latch `rs_val` and `rt_val` into the held operand registers.
  - Set select to 0 for MULT or 1 for DIV.
  - Load the counter with `MUL_CYCLES-1` or `DIV_CYCLES-1`.
  - Go to RUN.
- IDLE, MTHI or MTLO accepted: write `rs_val` into `hi` or `lo` at the next edge and stay in IDLE.
- IDLE, MFHI or MFLO: `mf_data` presents the current `hi` or `lo` in the same cycle; there is no state change.
- RUN, counter not 0: decrement the counter.
- RUN, counter 0: capture `outH` into `hi` and `outL` into `lo`, then go to IDLE.
- Result mapping: for MULT, `hi`/`lo` are the upper and lower product words. For DIV, `lo` is the quotient and `hi` is the remainder.
- Signedness and divide-by-zero results are whatever `mul_div_unit` produces. They are captured unchanged, with no trap.
- Flush in RUN: return to IDLE and leave `hi`/`lo` unchanged. A flush on the capture edge wins, so no capture takes place.
- Flush in the same cycle as `op_valid`: the op is ignored.
- Reset mid-operation: return to reset values on the next edge.

## Timing
- MULT/DIV accepted at edge k:
  - `busy` is high from cycle k through cycle k+N-1, where N is the relevant cycle count.
  - `hi`/`lo` hold the new values from edge k+N.
  - `busy` is low in cycle k+N.
- A stalled MFHI issued during RUN proceeds in cycle k+N and reads the new value. No forwarding is required.
- MTHI/MTLO: one cycle; the value is visible from the next edge.
- Back-to-back MULT/DIV: the second op stalls until `busy` drops, so it is accepted at edge k+N+1 at the earliest.
- The unit's inputs change only on acceptance edges, so the unit's paths are constrained as multicycle paths of N.

## Structure
- `muldiv_pkg` holds:
  - op encodings: NOP=0, MULT=1, DIV=2, MTHI=3, MTLO=4, MFHI=5, MFLO=6, with 7 reserved and treated as NOP;
  - state encodings: IDLE=0, RUN=1;
  - a helper function `is_md_op`.
- One sub-module: the existing `mul_div_unit`, instantiated internally and driven by the held operand registers and the select register.

## Test plan
- Reset, then MULT rs=6, rt=7 at default parameters:
  - `busy` is high for 2 cycles;
  - `hi`=0 and `lo`=42 from edge k+2.
- DIV rs=100, rt=7 with MFHI issued the next cycle:
  - `stall` is high for the remaining busy cycles;
  - then `mf_data`=2, and `lo`=14.
- MTLO 0xDEADBEEF, then MFLO next cycle: `mf_data`=0xDEADBEEF with no stall.
- DIV in flight with `flush` asserted in cycle k+1:
  - `busy` drops at the next edge;
  - `hi`/`lo` keep their prior values.
- Flush asserted exactly on the capture cycle: no HI/LO update.
- `rst` asserted mid-DIV: `hi`=`lo`=0, `busy`=0 and `stall`=0 after the next edge. A new MULT is then accepted immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MULT = 3'd1,
        OP_DIV  = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4,
        OP_MFHI = 3'd5,
        OP_MFLO = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Any op that touches HI/LO or the unit; these must wait out a computation.
    function automatic logic is_md_op(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd6);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Combinational signed multiply/divide. Divide by zero yields quotient all-ones
// and remainder = dividend; MIN/-1 yields quotient = dividend, remainder 0.
module mul_div_unit (
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        sel,
    output logic [31:0] outH,
    output logic [31:0] outL
);

    logic signed [63:0] aExt;
    logic signed [63:0] bExt;
    logic signed [63:0] prod;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign aExt = {{32{opA[31]}}, opA};
    assign bExt = {{32{opB[31]}}, opB};
    assign prod = aExt * bExt;

    always_comb begin
        quot = '0;
        rem  = '0;
        if (opB == 32'd0) begin
            quot = '1;
            rem  = opA;
        end else if (opA == 32'h8000_0000 && opB == 32'hFFFF_FFFF) begin
            quot = opA;
            rem  = '0;
        end else begin
            quot = $signed(opA) / $signed(opB);
            rem  = $signed(opA) % $signed(opB);
        end
    end

    assign outH = sel ? rem  : prod[63:32];
    assign outL = sel ? quot : prod[31:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// Multicycle sequencer owning HI/LO: holds operands stable for the unit's
// multicycle paths, then captures the result.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output state_t      dbgState
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    heldA;
    logic [31:0]    heldB;
    logic           sel;
    logic [31:0]    outH;
    logic [31:0]    outL;
    logic           accept;

    mul_div_unit u_unit (
        .opA  (heldA),
        .opB  (heldB),
        .sel  (sel),
        .outH (outH),
        .outL (outL)
    );

    // Handshake: op_valid is the offer, !stall is the ready; a flush kills the offer.
    assign stall    = op_valid && busy && is_md_op(op_code);
    assign accept   = op_valid && !stall && !flush;
    assign dbgState = state;

    always_comb begin
        mf_data = '0;
        if (op_code == OP_MFHI)
            mf_data = hi;
        else if (op_code == OP_MFLO)
            mf_data = lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            heldA <= '0;
            heldB <= '0;
            sel   <= 1'b0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_code)
                            OP_MULT, OP_DIV: begin
                                heldA <= rs_val;
                                heldB <= rt_val;
                                sel   <= (op_code == OP_DIV);
                                cnt   <= (op_code == OP_DIV) ? CW'(DIV_CYCLES - 1)
                                                             : CW'(MUL_CYCLES - 1);
                                busy  <= 1'b1;
                                state <= ST_RUN;
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // A flush on the capture edge takes priority: nothing is written.
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        hi    <= outH;
                        lo    <= outL;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed plan plus random traffic against a
// cycle-count reference model of HI/LO behaviour.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MULC = 2;
    localparam int DIVC = 4;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;
    state_t      dbgState;

    int errors = 0;
    int checks = 0;
    logic checkEn = 1'b0;

    // Reference model: architectural HI/LO, pending result, cycles left
    logic [31:0] mHi, mLo, pendHi, pendLo;
    int          remaining;
    logic [31:0] exp_q[$];

    muldiv_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_code  (op_code),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .mf_data  (mf_data),
        .hi       (hi),
        .lo       (lo),
        .dbgState (dbgState)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void compute(input logic isDiv, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!isDiv) begin
            p  = sa * sb;
            rh = p[63:32];
            rl = p[31:0];
        end else if (b == 32'd0) begin
            rh = a;
            rl = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rh = r[31:0];
            rl = q[31:0];
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mHi = 0; mLo = 0; pendHi = 0; pendLo = 0; remaining = 0;
        end else if (remaining > 0) begin
            if (flush) remaining = 0;
            else if (remaining == 1) begin
                mHi = pendHi; mLo = pendLo; remaining = 0;
            end else remaining = remaining - 1;
        end else if (op_valid && !flush) begin
            case (op_code)
                3'd1: begin compute(1'b0, rs_val, rt_val, pendHi, pendLo); remaining = MULC; end
                3'd2: begin compute(1'b1, rs_val, rt_val, pendHi, pendLo); remaining = DIVC; end
                3'd3: mHi = rs_val;
                3'd4: mLo = rs_val;
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic expStall;
        logic [31:0] expMf;
        if (checkEn) begin
            expStall = op_valid && (remaining > 0) && (op_code >= 3'd1) && (op_code <= 3'd6);
            expMf    = (op_code == 3'd5) ? mHi : (op_code == 3'd6) ? mLo : 32'd0;
            check("cyc_stall", {31'd0, stall}, {31'd0, expStall});
            check("cyc_busy",  {31'd0, busy},  {31'd0, remaining > 0});
            check("cyc_mf",    mf_data, expMf);
            check("cyc_hi",    hi, mHi);
            check("cyc_lo",    lo, mLo);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic v, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic f);
        op_valid = v; op_code = code; rs_val = a; rt_val = b; flush = f;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op_code = 3'd0; flush = 1'b0;
        #1;
    endtask

    task automatic nop();
        issue(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int stallCnt;
        logic [31:0] sHi, sLo;
        rst = 1'b1; op_valid = 0; op_code = 0; rs_val = 0; rt_val = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; checkEn = 1'b1;
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // MULT 6*7
        issue(1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
        check("mult_busy_k", {31'd0, busy}, 32'd1);
        nop();
        check("mult_busy_k1", {31'd0, busy}, 32'd1);
        nop();
        check("mult_busy_k2", {31'd0, busy}, 32'd0);
        check("mult_hi", hi, 32'd0);
        check("mult_lo", lo, 32'd42);

        // DIV 100/7 followed by a stalled MFHI
        issue(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
        op_valid = 1'b1; op_code = 3'd5;
        stallCnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!stall) break;
            stallCnt++;
            @(posedge clk);
            #1;
        end
        check("div_stall_cycles", 32'(stallCnt), 32'(DIVC));
        check("div_mfhi", mf_data, 32'd2);
        check("div_lo", lo, 32'd14);
        @(posedge clk); #1; op_valid = 1'b0; op_code = 3'd0; #1;

        // MTLO then MFLO
        issue(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        op_valid = 1'b1; op_code = 3'd6; #1;
        check("mflo_stall", {31'd0, stall}, 32'd0);
        check("mflo_data", mf_data, 32'hDEAD_BEEF);
        @(posedge clk); #1; op_valid = 1'b0; op_code = 3'd0; #1;

        // DIV flushed in cycle k+1
        issue(1'b1, 3'd2, 32'd50, 32'd3, 1'b0);
        nop();
        issue(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (4) nop();
        check("flush_hi", hi, 32'd2);
        check("flush_lo", lo, 32'hDEAD_BEEF);

        // Flush exactly on the capture cycle
        issue(1'b1, 3'd2, 32'd9, 32'd2, 1'b0);
        repeat (3) nop();
        check("capflush_busy_before", {31'd0, busy}, 32'd1);
        issue(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check("capflush_busy", {31'd0, busy}, 32'd0);
        check("capflush_hi", hi, 32'd2);
        check("capflush_lo", lo, 32'hDEAD_BEEF);

        // Reset mid-DIV, then immediate MULT
        issue(1'b1, 3'd2, 32'd1000, 32'd3, 1'b0);
        nop();
        rst = 1'b1; nop(); rst = 1'b0;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd5; rt_val = 32'd6; #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        issue(1'b1, 3'd1, 32'd5, 32'd6, 1'b0);
        check("rst_mult_busy", {31'd0, busy}, 32'd1);
        repeat (2) nop();
        check("rst_mult_lo", lo, 32'd30);

        // Signed / corner results pinned by hand
        issue(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        repeat (2) nop();
        check("neg_mult_hi", hi, 32'hFFFF_FFFF);
        check("neg_mult_lo", lo, 32'hFFFF_FFFA);
        issue(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        repeat (4) nop();
        check("neg_div_lo", lo, 32'hFFFF_FFFD);
        check("neg_div_hi", hi, 32'hFFFF_FFFF);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            issue(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)),
                  rand_operand(), rand_operand(), ($urandom_range(0, 19) == 0));
            rst = 1'b0;
            exp_q.push_back(mLo);
            if (exp_q.size() > 4) void'(exp_q.pop_front());
        end
        repeat (6) nop();

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
